// File: rtl/pokey_aud_divider.sv
// pokey_aud_divider: AUDF compare registers, down-counters and borrow pulse
// generation for one POKEY audio channel pair (split 8-bit or joined 16-bit).
// Optional feature macro: POKEY_FAST_OFFSET_EN adds the fast-clock reload
// offsets (+3 per channel when split, +6 when joined); without it the fast
// bit only selects the tick source.
module pokey_aud_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_base,
  input  logic         tick_fast,
  input  logic         fast_lo,
  input  logic         fast_hi,
  input  logic         join16,
  input  logic         audf_lo_wr,
  input  logic         audf_hi_wr,
  input  logic [W-1:0] wdata,
  input  logic         stimer,
  output logic         borrow_lo,
  output logic         borrow_hi
);

  localparam int SW = W + 1;
  localparam int JW = 2 * W + 1;

`ifdef POKEY_FAST_OFFSET_EN
  localparam logic [SW-1:0] SPLIT_OFS = SW'(3);
  localparam logic [JW-1:0] JOIN_OFS  = JW'(6);
`else
  localparam logic [SW-1:0] SPLIT_OFS = '0;
  localparam logic [JW-1:0] JOIN_OFS  = '0;
`endif

  typedef enum logic [1:0] {
    SPLIT  = 2'd0,
    JOINED = 2'd1,
    RESYNC = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            joinLatched_q;
  logic [W-1:0]    audfLo_q, audfHi_q;
  logic [SW-1:0]   cntLo_q, cntHi_q;
  logic [JW-1:0]   cntJ_q;
  logic            borrowLo_q, borrowHi_q;

  logic            resyncReq;
  logic            countSplit;
  logic            countJoined;
  logic            doReload;
  logic            ceLo, ceHi;
  logic [SW-1:0]   reloadLo, reloadHi;
  logic [JW-1:0]   reloadJ;

  assign ceLo = fast_lo ? tick_fast : tick_base;
  assign ceHi = fast_hi ? tick_fast : tick_base;

  assign reloadLo = {1'b0, audfLo_q} + (fast_lo ? SPLIT_OFS : '0);
  assign reloadHi = {1'b0, audfHi_q} + (fast_hi ? SPLIT_OFS : '0);
  assign reloadJ  = {1'b0, audfHi_q, audfLo_q} + (fast_lo ? JOIN_OFS : '0);

  // FSM state register; reset parks the pair in RESYNC so counters get loaded
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RESYNC;
    else        state_q <= state_d;
  end

  // Next state: RESYNC is a single cycle, a restart or mode change re-enters it
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESYNC:        state_d = join16 ? JOINED : SPLIT;
      SPLIT, JOINED: if (resyncReq) state_d = RESYNC;
      default:       state_d = RESYNC;
    endcase
  end

  // FSM outputs: which datapath may count this cycle, and when to reload
  always_comb begin
    resyncReq   = (state_q != RESYNC) && (stimer || (join16 != joinLatched_q));
    countSplit  = (state_q == SPLIT) && !resyncReq;
    countJoined = (state_q == JOINED) && !resyncReq;
    doReload    = (state_q == RESYNC);
  end

  // Remember the mode chosen on leaving RESYNC so a later change can be seen
  always_ff @(posedge clk) begin
    if (!rst_n)                 joinLatched_q <= 1'b0;
    else if (state_q == RESYNC) joinLatched_q <= join16;
  end

  // AUDF registers; writes never touch the running counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      audfLo_q <= '0;
      audfHi_q <= '0;
    end else begin
      if (audf_lo_wr) audfLo_q <= wdata;
      if (audf_hi_wr) audfHi_q <= wdata;
    end
  end

  // Lower split counter: count down on its enable, reload on borrow
  always_ff @(posedge clk) begin
    if (!rst_n)                  cntLo_q <= '0;
    else if (doReload)           cntLo_q <= reloadLo;
    else if (countSplit && ceLo) cntLo_q <= (cntLo_q == '0) ? reloadLo : cntLo_q - 1'b1;
  end

  // Upper split counter: same as the lower one but on its own enable
  always_ff @(posedge clk) begin
    if (!rst_n)                  cntHi_q <= '0;
    else if (doReload)           cntHi_q <= reloadHi;
    else if (countSplit && ceHi) cntHi_q <= (cntHi_q == '0) ? reloadHi : cntHi_q - 1'b1;
  end

  // Joined counter: one wide divider driven by the lower channel enable
  always_ff @(posedge clk) begin
    if (!rst_n)                   cntJ_q <= '0;
    else if (doReload)            cntJ_q <= reloadJ;
    else if (countJoined && ceLo) cntJ_q <= (cntJ_q == '0) ? reloadJ : cntJ_q - 1'b1;
  end

  // Registered one-cycle borrow pulses; joined borrows appear on the upper output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      borrowLo_q <= 1'b0;
      borrowHi_q <= 1'b0;
    end else begin
      borrowLo_q <= countSplit && ceLo && (cntLo_q == '0);
      borrowHi_q <= (countSplit && ceHi && (cntHi_q == '0)) ||
                    (countJoined && ceLo && (cntJ_q == '0));
    end
  end

  assign borrow_lo = borrowLo_q;
  assign borrow_hi = borrowHi_q;

endmodule
